uart_frame_ctrl: RTL and testbench
==================================

Name: uart_frame_ctrl

Overview:
- Frame-level controller behind uart_receive; consumes its byte stream (data_byte_out / new_data_out).
- Hunts for a sync byte, reads a length, buffers the payload and checks an 8-bit checksum.
- Releases the payload to downstream logic over a valid/ready handshake only if the frame is good.
- Reports framing errors (bad length, bad checksum, inter-byte timeout, overrun) as one-cycle pulses with a code.

Parameters:
- SYNC_BYTE, 8'hA5: frame start marker.
- MAX_LEN, 16: maximum payload length in bytes; legal LEN is 1..MAX_LEN, with MAX_LEN ≤ 255.
- TIMEOUT_CYCLES, 1_000_000: clk_in cycles of silence allowed between bytes inside a frame.

Ports:
- clk_in, input, 1: system clock.
- rst_in, input, 1: reset, asynchronous, active-high.
- byte_in, input, 8: received byte; valid only when byte_valid_in = 1.
- byte_valid_in, input, 1: one-cycle strobe per received byte.
- payload_data_out, output, 8: payload byte being offered.
- payload_valid_out, output, 1: payload byte available.
- payload_ready_in, input, 1: downstream accepts the byte.
- payload_last_out, output, 1: the offered byte is the final byte of the frame.
- frame_done_out, output, 1: one-cycle pulse after the last payload transfer.
- frame_error_out, output, 1: one-cycle pulse on frame discard.
- error_code_out, output, 2: 1 = bad length, 2 = bad checksum, 3 = timeout. Holds its value until the next error.
- overrun_out, output, 1: one-cycle pulse when a byte is dropped during DRAIN.
- busy_out, output, 1: high in any state other than HUNT.

Behaviour:
- Reset: asserting rst_in asynchronously forces state HUNT and zeroes every output, the counters and the checksum accumulator. Buffer contents are don't-care. Reset mid-frame or mid-drain abandons the frame with no error pulse.
- Frame format: SYNC, LEN, LEN payload bytes, CK. The frame is good iff (LEN + sum of payload + CK) mod 256 == 0, using 8-bit wrap-around addition.
- HUNT: any byte other than SYNC_BYTE is ignored. SYNC_BYTE goes to LEN; the timeout counter and the accumulator are cleared.
- LEN:
  - LEN == 0 or LEN > MAX_LEN → error code 1, back to HUNT.
  - Otherwise store LEN, set accumulator = LEN, write index = 0, go to PAYLOAD.
- PAYLOAD: each byte is written to buf[index] and added to the accumulator; index increments. When the LEN-th byte is stored, go to CHECK.
- CHECK: on the CK byte, if (acc + CK) mod 256 == 0 go to DRAIN with read index 0; else error code 2 and back to HUNT.
- Error pulse timing: frame_error_out pulses in the cycle after the offending byte strobe, and error_code_out updates in that same cycle.
- DRAIN:
  - payload_valid_out = 1 and payload_data_out = buf[rd_idx], starting the cycle after the CK strobe.
  - A transfer occurs when valid && ready; rd_idx then increments.
  - Data stays stable while ready is low.
  - payload_last_out = 1 while rd_idx == LEN-1.
  - After the last transfer: valid drops next cycle, frame_done_out pulses that cycle, state goes to HUNT.
- Timeout:
  - In LEN, PAYLOAD and CHECK, a counter increments every cycle and clears on each byte strobe.
  - When it reaches TIMEOUT_CYCLES - 1 with no strobe: error code 3, back to HUNT.
  - A byte strobe in the same cycle wins: the byte is processed and the counter clears.
  - The counter is held at 0 in HUNT and DRAIN.
- Overrun: a byte strobe during DRAIN is discarded and overrun_out pulses the next cycle. Drain continues normally; that byte is not treated as SYNC.
- Widths: index counters are $clog2(MAX_LEN+1) bits; the accumulator is 8 bits; the timeout counter is $clog2(TIMEOUT_CYCLES+1) bits.

Optional Feature:
- Macro: UART_FRAME_STATS_EN.
- When defined, adds three outputs: good_frames_out[15:0], error_frames_out[15:0] and overrun_count_out[15:0].
  - They increment on frame_done_out, frame_error_out and overrun_out respectively.
  - They saturate at 16'hFFFF and clear on rst_in.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Good frame, payload_ready_in = 1: bytes A5 03 11 22 33 97.
  - Required: payload 11, 22, 33 on three consecutive cycles starting the cycle after the 97 strobe; last = 1 on 33; frame_done_out pulse; no error.
- Bad checksum: bytes A5 03 11 22 33 98.
  - Required: frame_error_out pulse with code 2; payload_valid_out never asserted; busy_out = 0 afterwards.
- Bad length: A5 00 gives error code 1; A5 11 (17 > 16) gives error code 1.
  - A following good frame, A5 01 42 BD, delivers 42 with last = 1.
- Timeout with TIMEOUT_CYCLES = 100: send A5 02 10, then 100 idle cycles.
  - Required: error code 3 pulse.
  - A following good frame, A5 02 10 20 CE, delivers 10, 20.
- Backpressure and overrun: good 3-byte frame with ready low for 5 cycles after the first transfer, plus one byte strobe (A5) during DRAIN.
  - Required: data held at 22 while stalled; overrun_out pulse; all three bytes delivered in order; frame_done_out pulse.
- Reset mid-frame: assert rst_in after A5 03 11.
  - Required: immediately all outputs 0 and busy_out = 0; no error pulse.
  - A following good frame is delivered correctly.

Source files
------------

// File: rtl/uart_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_frame_ctrl
//
// Frame-level controller that sits behind a UART byte receiver. It hunts for a
// sync byte, reads a length byte, buffers the payload, then checks an 8-bit
// checksum. Only a good frame is offered downstream over a valid/ready
// handshake. Framing problems are reported as one-cycle pulses with a code.
//
// Frame on the wire: SYNC, LEN, LEN payload bytes, CK.
// The frame is good iff (LEN + sum(payload) + CK) mod 256 == 0.
//
// Optional build macro: UART_FRAME_STATS_EN adds saturating 16-bit event
// counters (good_frames_out, error_frames_out, overrun_count_out).
//
// Ports:
//   clk_in            - system clock
//   rst_in            - asynchronous, active-high reset
//   byte_in           - received byte, valid when byte_valid_in = 1
//   byte_valid_in     - one-cycle strobe per received byte
//   payload_data_out  - payload byte being offered
//   payload_valid_out - payload byte available
//   payload_ready_in  - downstream accepts the byte
//   payload_last_out  - offered byte is the final byte of the frame
//   frame_done_out    - one-cycle pulse after the last payload transfer
//   frame_error_out   - one-cycle pulse when a frame is discarded
//   error_code_out    - 1 bad length, 2 bad checksum, 3 timeout (held)
//   overrun_out       - one-cycle pulse when a byte is dropped while draining
//   busy_out          - high whenever not hunting for sync
// -----------------------------------------------------------------------------
module uart_frame_ctrl #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid_in,
    output logic [7:0]  payload_data_out,
    output logic        payload_valid_out,
    input  logic        payload_ready_in,
    output logic        payload_last_out,
    output logic        frame_done_out,
    output logic        frame_error_out,
    output logic [1:0]  error_code_out,
    output logic        overrun_out,
`ifdef UART_FRAME_STATS_EN
    output logic [15:0] good_frames_out,
    output logic [15:0] error_frames_out,
    output logic [15:0] overrun_count_out,
`endif
    output logic        busy_out
);

    localparam int IDX_W  = $clog2(MAX_LEN + 1);
    localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [2:0] ST_HUNT    = 3'd0;
    localparam logic [2:0] ST_LEN     = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_CHECK   = 3'd3;
    localparam logic [2:0] ST_DRAIN   = 3'd4;

    localparam logic [1:0] ERR_LEN = 2'd1;
    localparam logic [1:0] ERR_CK  = 2'd2;
    localparam logic [1:0] ERR_TMO = 2'd3;

    logic [2:0]       state_q, state_d;
    logic [IDX_W-1:0] len_q, len_d;
    logic [IDX_W-1:0] wr_q, wr_d;
    logic [IDX_W-1:0] rd_q, rd_d;
    logic [7:0]       acc_q, acc_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_pulse_q, err_pulse_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             overrun_q, overrun_d;
    logic             done_q, done_d;

    logic             wr_en;
    logic [7:0]       ck_sum;
    logic [IDX_W-1:0] len_m1;
    logic             in_frame;
    logic             xfer;

    // Payload storage; contents are irrelevant until written, so no reset.
    logic [7:0] buf_mem [MAX_LEN];

    assign len_m1   = len_q - IDX_ONE;
    assign in_frame = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);
    assign xfer     = (state_q == ST_DRAIN) && payload_ready_in;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        acc_d       = acc_q;
        tmo_d       = tmo_q;
        err_pulse_d = 1'b0;
        err_code_d  = err_code_q;
        overrun_d   = 1'b0;
        done_d      = 1'b0;
        wr_en       = 1'b0;
        ck_sum      = acc_q + byte_in;

        case (state_q)
            ST_HUNT: begin
                tmo_d = '0;
                if (byte_valid_in && (byte_in == SYNC_BYTE)) begin
                    state_d = ST_LEN;
                    acc_d   = '0;
                end
            end
            ST_LEN: begin
                if (byte_valid_in) begin
                    tmo_d = '0;
                    if ((byte_in == 8'd0) || (byte_in > MAX_LEN_B)) begin
                        state_d     = ST_HUNT;
                        err_pulse_d = 1'b1;
                        err_code_d  = ERR_LEN;
                    end else begin
                        len_d   = byte_in[IDX_W-1:0];
                        acc_d   = byte_in;
                        wr_d    = '0;
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (byte_valid_in) begin
                    tmo_d = '0;
                    wr_en = 1'b1;
                    acc_d = ck_sum;
                    wr_d  = wr_q + IDX_ONE;
                    if (wr_q == len_m1) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (byte_valid_in) begin
                    tmo_d = '0;
                    if (ck_sum == 8'd0) begin
                        state_d = ST_DRAIN;
                        rd_d    = '0;
                    end else begin
                        state_d     = ST_HUNT;
                        err_pulse_d = 1'b1;
                        err_code_d  = ERR_CK;
                    end
                end
            end
            ST_DRAIN: begin
                tmo_d = '0;
                // Bytes arriving while draining are dropped, never parsed as sync.
                if (byte_valid_in) begin
                    overrun_d = 1'b1;
                end
                if (xfer) begin
                    if (rd_q == len_m1) begin
                        state_d = ST_HUNT;
                        done_d  = 1'b1;
                    end else begin
                        rd_d = rd_q + IDX_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase

        // Inter-byte silence watchdog; a strobe in the same cycle takes priority.
        if (in_frame && !byte_valid_in) begin
            if (tmo_q == TMO_LAST) begin
                state_d     = ST_HUNT;
                err_pulse_d = 1'b1;
                err_code_d  = ERR_TMO;
                tmo_d       = '0;
            end else begin
                tmo_d = tmo_q + TMO_ONE;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= ST_HUNT;
            len_q       <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            acc_q       <= '0;
            tmo_q       <= '0;
            err_pulse_q <= 1'b0;
            err_code_q  <= 2'd0;
            overrun_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            acc_q       <= acc_d;
            tmo_q       <= tmo_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
            overrun_q   <= overrun_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            buf_mem[wr_q[ADDR_W-1:0]] <= byte_in;
        end
    end

    // Data is gated to zero outside DRAIN so reset leaves every output at 0.
    assign payload_valid_out = (state_q == ST_DRAIN);
    assign payload_data_out  = (state_q == ST_DRAIN) ? buf_mem[rd_q[ADDR_W-1:0]] : 8'h00;
    assign payload_last_out  = (state_q == ST_DRAIN) && (rd_q == len_m1);
    assign frame_done_out    = done_q;
    assign frame_error_out   = err_pulse_q;
    assign error_code_out    = err_code_q;
    assign overrun_out       = overrun_q;
    assign busy_out          = (state_q != ST_HUNT);

`ifdef UART_FRAME_STATS_EN
    logic [15:0] good_cnt_q;
    logic [15:0] err_cnt_q;
    logic [15:0] ovr_cnt_q;

    // Counters follow the visible pulses and stick at all-ones.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            good_cnt_q <= '0;
            err_cnt_q  <= '0;
            ovr_cnt_q  <= '0;
        end else begin
            if (done_q && (good_cnt_q != 16'hFFFF)) begin
                good_cnt_q <= good_cnt_q + 16'd1;
            end
            if (err_pulse_q && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
            if (overrun_q && (ovr_cnt_q != 16'hFFFF)) begin
                ovr_cnt_q <= ovr_cnt_q + 16'd1;
            end
        end
    end

    assign good_frames_out   = good_cnt_q;
    assign error_frames_out  = err_cnt_q;
    assign overrun_count_out = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_ctrl
//
// Self-checking bench for uart_frame_ctrl (MAX_LEN = 16, TIMEOUT_CYCLES = 100).
// Directed frames exercise exact pulse timing; random frames are scored against
// a frame-level reference that applies the checksum/length rules directly.
// -----------------------------------------------------------------------------
module tb_uart_frame_ctrl;

    localparam int MAX_LEN = 16;
    localparam int TMO     = 100;

    logic       clk = 1'b0;
    logic       rst_in;
    logic [7:0] byte_in;
    logic       byte_valid_in;
    logic [7:0] payload_data_out;
    logic       payload_valid_out;
    logic       payload_ready_in;
    logic       payload_last_out;
    logic       frame_done_out;
    logic       frame_error_out;
    logic [1:0] error_code_out;
    logic       overrun_out;
    logic       busy_out;
`ifdef UART_FRAME_STATS_EN
    logic [15:0] good_frames_out;
    logic [15:0] error_frames_out;
    logic [15:0] overrun_count_out;
`endif

    uart_frame_ctrl #(
        .SYNC_BYTE     (8'hA5),
        .MAX_LEN       (MAX_LEN),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst_in),
        .byte_in          (byte_in),
        .byte_valid_in    (byte_valid_in),
        .payload_data_out (payload_data_out),
        .payload_valid_out(payload_valid_out),
        .payload_ready_in (payload_ready_in),
        .payload_last_out (payload_last_out),
        .frame_done_out   (frame_done_out),
        .frame_error_out  (frame_error_out),
        .error_code_out   (error_code_out),
        .overrun_out      (overrun_out),
`ifdef UART_FRAME_STATS_EN
        .good_frames_out  (good_frames_out),
        .error_frames_out (error_frames_out),
        .overrun_count_out(overrun_count_out),
`endif
        .busy_out         (busy_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Observed events
    logic [8:0] got_q[$];
    int         got_err[$];
    int         got_done = 0;
    int         got_ovr  = 0;
    // Expected events
    logic [8:0] exp_q[$];
    int         exp_err[$];
    int         exp_done = 0;
    int         exp_ovr  = 0;
    int         all_done = 0;

    logic [7:0] fr_q[$];
    int         rdy_mode     = 0;
    logic       manual_ready = 1'b1;
    logic       prev_stall   = 1'b0;
    logic [7:0] prev_data    = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame-level reference: outcome follows from LEN and the byte sum alone.
    task automatic model_frame(input logic [7:0] fr[$]);
        int         len;
        logic [7:0] sum;
        len = int'(fr[1]);
        if (len == 0 || len > MAX_LEN) begin
            exp_err.push_back(1);
        end else begin
            sum = 8'h00;
            for (int i = 1; i < fr.size(); i++) sum = sum + fr[i];
            if (sum == 8'h00) begin
                for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), fr[2 + i]});
                exp_done++;
                all_done++;
            end else begin
                exp_err.push_back(2);
            end
        end
    endtask

    // n_idle = number of strobe-free cycles between the previous strobe and this one
    task automatic send_byte(input logic [7:0] b, input int n_idle);
        repeat (n_idle - 1) @(posedge clk);
        @(posedge clk); #1;
        byte_in       = b;
        byte_valid_in = 1'b1;
        @(posedge clk); #1;
        byte_valid_in = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] fr[$], input int gap_max);
        foreach (fr[i]) send_byte(fr[i], $urandom_range(1, gap_max));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_out && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 1000) chk("idle_bound", busy_out, 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, "_npay"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, "_pay"}, got_q[i], exp_q[i]);
        chk({tag, "_nerr"}, got_err.size(), exp_err.size());
        for (int i = 0; i < exp_err.size() && i < got_err.size(); i++)
            chk({tag, "_err"}, got_err[i], exp_err[i]);
        chk({tag, "_done"}, got_done, exp_done);
        chk({tag, "_ovr"}, got_ovr, exp_ovr);
        got_q.delete(); exp_q.delete(); got_err.delete(); exp_err.delete();
        got_done = 0; exp_done = 0; got_ovr = 0; exp_ovr = 0;
    endtask

    // Ready driver: fixed value or random per cycle
    initial begin
        payload_ready_in = 1'b1;
        forever begin
            @(posedge clk); #2;
            payload_ready_in = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : manual_ready;
        end
    end

    // Event monitor and hold-while-stalled check
    always @(negedge clk) begin
        if (rst_in) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", payload_valid_out, 1);
                chk("hold_data", payload_data_out, prev_data);
            end
            if (payload_valid_out && payload_ready_in) got_q.push_back({payload_last_out, payload_data_out});
            if (frame_done_out) got_done++;
            if (frame_error_out) got_err.push_back(int'(error_code_out));
            if (overrun_out) got_ovr++;
            prev_stall = payload_valid_out && !payload_ready_in;
            prev_data  = payload_data_out;
        end
    end

    initial begin
        #800_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int         kind;
        int         len;
        logic [7:0] b;
        logic [7:0] sum;

        rst_in        = 1'b1;
        byte_in       = 8'h00;
        byte_valid_in = 1'b0;
        #1;
        chk("rst_busy", busy_out, 0);
        chk("rst_valid", payload_valid_out, 0);
        chk("rst_code", error_code_out, 0);
        chk("rst_err", frame_error_out, 0);
        #12;
        rst_in = 1'b0;

        // Good frame with exact delivery timing
        fr_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        model_frame(fr_q);
        send_frame(fr_q, 1);
        @(negedge clk);
        chk("g1_v", payload_valid_out, 1); chk("g1_d", payload_data_out, 8'h11); chk("g1_l", payload_last_out, 0);
        @(negedge clk);
        chk("g2_d", payload_data_out, 8'h22); chk("g2_l", payload_last_out, 0);
        @(negedge clk);
        chk("g3_d", payload_data_out, 8'h33); chk("g3_l", payload_last_out, 1);
        @(negedge clk);
        chk("g_vdrop", payload_valid_out, 0); chk("g_done", frame_done_out, 1); chk("g_busy", busy_out, 0);
        wait_idle();
        compare_all("good");

        // Bad checksum
        fr_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98};
        model_frame(fr_q);
        send_frame(fr_q, 1);
        @(negedge clk);
        chk("ck_pulse", frame_error_out, 1); chk("ck_code", error_code_out, 2);
        chk("ck_valid", payload_valid_out, 0); chk("ck_busy", busy_out, 0);
        wait_idle();
        compare_all("badck");

        // Bad lengths, then a good single-byte frame
        fr_q = '{8'hA5, 8'h00};
        model_frame(fr_q);
        send_frame(fr_q, 1);
        @(negedge clk);
        chk("len0_pulse", frame_error_out, 1); chk("len0_code", error_code_out, 1);
        fr_q = '{8'hA5, 8'h11};
        model_frame(fr_q);
        send_frame(fr_q, 2);
        @(negedge clk);
        chk("len17_pulse", frame_error_out, 1); chk("len17_code", error_code_out, 1);
        fr_q = '{8'hA5, 8'h01, 8'h42, 8'hBD};
        model_frame(fr_q);
        send_frame(fr_q, 1);
        @(negedge clk);
        chk("len_after_d", payload_data_out, 8'h42); chk("len_after_l", payload_last_out, 1);
        chk("code_held", error_code_out, 1);
        wait_idle();
        compare_all("badlen");

        // Timeout after 100 silent cycles
        fr_q = '{8'hA5, 8'h02, 8'h10};
        exp_err.push_back(3);
        send_frame(fr_q, 1);
        repeat (TMO - 1) @(posedge clk);
        @(negedge clk);
        chk("tmo_early", frame_error_out, 0);
        @(negedge clk);
        chk("tmo_pulse", frame_error_out, 1); chk("tmo_code", error_code_out, 3); chk("tmo_busy", busy_out, 0);
        wait_idle();
        fr_q = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'hCE};
        model_frame(fr_q);
        send_frame(fr_q, 1);
        wait_idle();
        compare_all("tmo");

        // 99 silent cycles between bytes is still within the limit
        fr_q = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'hCE};
        model_frame(fr_q);
        foreach (fr_q[i]) send_byte(fr_q[i], TMO - 1);
        wait_idle();
        compare_all("tmo_edge");

        // Backpressure with a byte dropped while draining
        fr_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        model_frame(fr_q);
        exp_ovr = 1;
        send_frame(fr_q, 1);
        @(posedge clk); #1;
        manual_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            byte_in       = 8'hA5;
            byte_valid_in = (i == 1);
            @(negedge clk);
            chk("bp_data", payload_data_out, 8'h22);
            chk("bp_valid", payload_valid_out, 1);
            @(posedge clk); #1;
        end
        byte_valid_in = 1'b0;
        manual_ready  = 1'b1;
        wait_idle();
        compare_all("bp");

        // Randomized frames against the reference
        for (int f = 0; f < 40; f++) begin
            rdy_mode = $urandom_range(0, 1);
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h5A;
                send_byte(b, $urandom_range(1, 3));
            end
            kind = $urandom_range(0, 9);
            fr_q.delete();
            fr_q.push_back(8'hA5);
            if (kind < 2) begin
                len = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(MAX_LEN + 1, 255);
                fr_q.push_back(len[7:0]);
            end else begin
                len = $urandom_range(1, MAX_LEN);
                fr_q.push_back(len[7:0]);
                sum = len[7:0];
                for (int i = 0; i < len; i++) begin
                    b = 8'($urandom_range(0, 255));
                    fr_q.push_back(b);
                    sum = sum + b;
                end
                b = 8'h00 - sum;
                if (kind < 4) b = b + 8'($urandom_range(1, 255));
                fr_q.push_back(b);
            end
            model_frame(fr_q);
            send_frame(fr_q, 4);
            wait_idle();
            compare_all("rnd");
        end
        rdy_mode     = 0;
        manual_ready = 1'b1;

        // Reset in the middle of a frame
        fr_q = '{8'hA5, 8'h03, 8'h11};
        send_frame(fr_q, 1);
        @(posedge clk); #3;
        rst_in = 1'b1;
        #1;
        chk("mrst_busy", busy_out, 0);
        chk("mrst_valid", payload_valid_out, 0);
        chk("mrst_data", payload_data_out, 0);
        chk("mrst_code", error_code_out, 0);
        chk("mrst_err", frame_error_out, 0);
        chk("mrst_done", frame_done_out, 0);
        @(posedge clk); #3;
        rst_in = 1'b0;
`ifdef UART_FRAME_STATS_EN
        all_done = 0;
`endif
        fr_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        model_frame(fr_q);
        send_frame(fr_q, 2);
        wait_idle();
        compare_all("mrst");
`ifdef UART_FRAME_STATS_EN
        chk("stat_good", good_frames_out, all_done);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
